// File: rtl/led_pkg.sv
// led_pkg: shared channel count, level width, register map, snap bit and FSM states for the LED fader
package led_pkg;
  localparam int NUM_CH = 33;
  localparam int LEVEL_W = 16;
  localparam logic [5:0] ADDR_STEP = 6'd33;
  localparam logic [5:0] ADDR_CMD = 6'd34;
  localparam int CMD_SNAP = 0;
  typedef enum logic {IDLE, SWEEP} state_t;
endpackage

// File: rtl/led_fade_step.sv
// led_fade_step: saturating step of level toward target (ports: level, target, step in; next_level out)
module led_fade_step #(
  parameter int LEVEL_W = led_pkg::LEVEL_W
) (
  input  logic [LEVEL_W-1:0] level,
  input  logic [LEVEL_W-1:0] target,
  input  logic [LEVEL_W-1:0] step,
  output logic [LEVEL_W-1:0] next_level
);
  logic [LEVEL_W:0] up, dn;
  assign up = {1'b0, level} + {1'b0, step};
  assign dn = {1'b0, level} - {1'b0, step};
  always_comb
    next_level = level < target ? (up > {1'b0, target} ? target : up[LEVEL_W-1:0]) :
                 level > target ? ((dn[LEVEL_W] || dn[LEVEL_W-1:0] < target) ? target : dn[LEVEL_W-1:0]) :
                 level;
endmodule

// File: rtl/led_fade_ctrl.sv
// led_fade_ctrl: per-tick fade sweep over all channels (ports: clk, rst, tick, wr_en/wr_addr/wr_data in; wr_err, busy, sweep_done, overrun, level_flat out)
module led_fade_ctrl #(
  parameter int NUM_CH = led_pkg::NUM_CH,
  parameter int LEVEL_W = led_pkg::LEVEL_W,
  parameter logic [LEVEL_W-1:0] STEP_RST = 16'd1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic                      wr_en,
  input  logic [5:0]                wr_addr,
  input  logic [LEVEL_W-1:0]        wr_data,
  output logic                      wr_err,
  output logic                      busy,
  output logic                      sweep_done,
  output logic                      overrun,
  output logic [NUM_CH*LEVEL_W-1:0] level_flat
);
  import led_pkg::*;
  localparam int IDX_W = $clog2(NUM_CH);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_CH - 1);
  localparam logic [5:0] CH_END = 6'(NUM_CH);
  state_t state, state_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic pending, pending_n, done_n, ovr_n, snap, last;
  logic [NUM_CH-1:0][LEVEL_W-1:0] target, level;
  logic [LEVEL_W-1:0] step, next_level;
  assign snap = wr_en && wr_addr == ADDR_CMD && wr_data[CMD_SNAP];
  assign last = state == SWEEP && idx == LAST;
  assign busy = state == SWEEP;
  assign level_flat = level;
  led_fade_step #(.LEVEL_W(LEVEL_W)) u_step (
    .level(level[idx]),
    .target(target[idx]),
    .step(step),
    .next_level(next_level)
  );
  always_comb begin
    state_n = state;
    idx_n = idx;
    pending_n = pending;
    done_n = 1'b0;
    ovr_n = 1'b0;
    if (snap) begin
      state_n = IDLE;
      idx_n = '0;
      pending_n = 1'b0;
    end else if (state == IDLE) begin
      state_n = tick ? SWEEP : IDLE;
      idx_n = '0;
    end else if (last) begin
      // a tick landing on the final cycle chains straight into the next sweep
      done_n = 1'b1;
      ovr_n = tick && pending;
      state_n = (pending || tick) ? SWEEP : IDLE;
      idx_n = '0;
      pending_n = 1'b0;
    end else begin
      idx_n = idx + 1'b1;
      ovr_n = tick && pending;
      pending_n = pending || tick;
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      pending <= 1'b0;
      sweep_done <= 1'b0;
      overrun <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      state <= state_n;
      idx <= idx_n;
      pending <= pending_n;
      sweep_done <= done_n;
      overrun <= ovr_n;
      wr_err <= wr_en && wr_addr > ADDR_CMD;
    end
  always_ff @(posedge clk)
    if (rst) begin
      target <= '0;
      level <= '0;
      step <= STEP_RST;
    end else begin
      if (wr_en && wr_addr < CH_END) target[wr_addr] <= wr_data;
      if (wr_en && wr_addr == ADDR_STEP) step <= wr_data;
      if (snap) level <= target;
      else if (state == SWEEP) level[idx] <= next_level;
    end
endmodule

// File: tb/tb_led_fade_ctrl.sv
// tb_led_fade_ctrl: scoreboard-driven checks of the LED fade controller
module tb_led_fade_ctrl;
  import led_pkg::*;
  localparam int W = LEVEL_W;
  logic clk = 0, rst = 1, tick = 0, wr_en = 0;
  logic [5:0] wr_addr = '0;
  logic [W-1:0] wr_data = '0;
  logic wr_err, busy, sweep_done, overrun;
  logic [NUM_CH*W-1:0] level_flat, exp_flat;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_v;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  led_fade_ctrl dut (
    .clk(clk), .rst(rst), .tick(tick), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_err(wr_err), .busy(busy), .sweep_done(sweep_done), .overrun(overrun), .level_flat(level_flat)
  );
  task automatic clk_step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [W-1:0] lvl(input int ch);
    return level_flat[W*ch +: W];
  endfunction
  task automatic wr(input logic [5:0] a, input logic [W-1:0] d);
    wr_en = 1; wr_addr = a; wr_data = d;
    clk_step;
    wr_en = 0;
  endtask
  task automatic sweep(input string name);
    bit ok = 0;
    tick = 1;
    clk_step;
    tick = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      clk_step;
      ok = sweep_done;
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL %s_timeout: sweep_done=%0b required 1", name, ok); end
  endtask
  task automatic test_reset;
    rst = 1;
    clk_step;
    clk_step;
    rst = 0;
    checks += 5;
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (sweep_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", sweep_done); end
    if (wr_err !== 1'b0) begin failures++; $display("FAIL rst_wr_err: got %b want 0", wr_err); end
    if (overrun !== 1'b0) begin failures++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    if (level_flat !== '0) begin failures++; $display("FAIL rst_levels: got %h want 0", level_flat); end
  endtask
  task automatic test_ramp;
    wr(6'd0, 16'h0010);
    wr(6'd33, 16'd4);
    for (int s = 0; s < 5; s++) begin
      exp_q.push_back(W'((s < 4 ? s + 1 : 4) * 4));
      sweep("ramp");
      exp_v = exp_q.pop_front();
      checks++;
      if (lvl(0) !== exp_v) begin failures++; $display("FAIL ramp_%0d: ch0 got %h want %h", s, lvl(0), exp_v); end
    end
  endtask
  task automatic test_saturate;
    exp_q.push_back(16'hFFF0);
    wr(6'd5, 16'hFFF0);
    wr(ADDR_CMD, 16'h0001);
    exp_v = exp_q.pop_front();
    checks++;
    if (lvl(5) !== exp_v) begin failures++; $display("FAIL snap_ch5: got %h want %h", lvl(5), exp_v); end
    exp_q.push_back(16'hFFFF);
    wr(6'd5, 16'hFFFF);
    wr(ADDR_STEP, 16'h0020);
    sweep("sat_up");
    exp_v = exp_q.pop_front();
    checks++;
    if (lvl(5) !== exp_v) begin failures++; $display("FAIL sat_up: ch5 got %h want %h", lvl(5), exp_v); end
    exp_q.push_back(16'hFFDF);
    wr(6'd5, 16'h0000);
    sweep("sat_dn");
    exp_v = exp_q.pop_front();
    checks++;
    if (lvl(5) !== exp_v) begin failures++; $display("FAIL sat_dn: ch5 got %h want %h", lvl(5), exp_v); end
  endtask
  task automatic test_back_to_back;
    int nb = 0, nd = 0, no = 0, ocyc = -1;
    exp_q.push_back(16'd66);
    exp_q.push_back(16'd2);
    exp_q.push_back(16'd1);
    exp_q.push_back(16'd21);
    exp_q.push_back(16'hFF9F);
    tick = 1;
    clk_step;
    for (int c = 0; c < 80; c++) begin
      nb += int'(busy);
      nd += int'(sweep_done);
      if (overrun) begin no++; ocyc = c; end
      tick = (c == 10 || c == 20);
      clk_step;
    end
    tick = 0;
    checks += 5;
    exp_v = exp_q.pop_front();
    if (W'(nb) !== exp_v) begin failures++; $display("FAIL b2b_busy_cycles: got %0d want %0d", nb, exp_v); end
    exp_v = exp_q.pop_front();
    if (W'(nd) !== exp_v) begin failures++; $display("FAIL b2b_done_pulses: got %0d want %0d", nd, exp_v); end
    exp_v = exp_q.pop_front();
    if (W'(no) !== exp_v) begin failures++; $display("FAIL b2b_overruns: got %0d want %0d", no, exp_v); end
    exp_v = exp_q.pop_front();
    if (W'(ocyc) !== exp_v) begin failures++; $display("FAIL b2b_overrun_cycle: got %0d want %0d", ocyc, exp_v); end
    exp_v = exp_q.pop_front();
    if (lvl(5) !== exp_v) begin failures++; $display("FAIL b2b_ch5: got %h want %h", lvl(5), exp_v); end
  endtask
  task automatic test_snap_abort;
    int nd = 0;
    exp_q.push_back(16'h1234);
    exp_q.push_back(16'h0000);
    wr(6'd7, 16'h1234);
    tick = 1;
    clk_step;
    tick = 0;
    for (int c = 0; c < 15; c++) clk_step;
    wr_en = 1; wr_addr = ADDR_CMD; wr_data = 16'h0001; tick = 1;
    clk_step;
    wr_en = 0; tick = 0;
    checks += 4;
    exp_v = exp_q.pop_front();
    if (lvl(7) !== exp_v) begin failures++; $display("FAIL snap_ch7: got %h want %h", lvl(7), exp_v); end
    exp_v = exp_q.pop_front();
    if (lvl(5) !== exp_v) begin failures++; $display("FAIL snap_ch5_zero: got %h want %h", lvl(5), exp_v); end
    if (busy !== 1'b0) begin failures++; $display("FAIL snap_busy: got %b want 0", busy); end
    if (sweep_done !== 1'b0) begin failures++; $display("FAIL snap_done: got %b want 0", sweep_done); end
    for (int c = 0; c < 40; c++) begin
      clk_step;
      nd += int'(sweep_done) + int'(busy);
    end
    checks++;
    if (nd != 0) begin failures++; $display("FAIL snap_quiet: got %0d busy/done cycles want 0", nd); end
    exp_q.push_back(16'h1234);
    wr(6'd7, 16'h0001);
    wr(ADDR_CMD, 16'hFFFE);
    exp_v = exp_q.pop_front();
    checks++;
    if (lvl(7) !== exp_v) begin failures++; $display("FAIL cmd_nosnap: ch7 got %h want %h", lvl(7), exp_v); end
  endtask
  task automatic test_invalid_and_rst;
    wr(6'd7, 16'h1234);
    exp_flat = '0;
    exp_flat[W*0 +: W] = 16'h0010;
    exp_flat[W*7 +: W] = 16'h1234;
    wr(6'd40, 16'hFFFF);
    checks++;
    if (wr_err !== 1'b1) begin failures++; $display("FAIL wr_err_pulse: got %b want 1", wr_err); end
    clk_step;
    checks += 2;
    if (wr_err !== 1'b0) begin failures++; $display("FAIL wr_err_clear: got %b want 0", wr_err); end
    if (level_flat !== exp_flat) begin failures++; $display("FAIL invalid_levels: got %h want %h", level_flat, exp_flat); end
    wr(6'd1, 16'h0100);
    sweep("invalid");
    exp_flat[W*1 +: W] = 16'h0020;
    checks++;
    if (level_flat !== exp_flat) begin failures++; $display("FAIL invalid_step: got %h want %h", level_flat, exp_flat); end
    tick = 1;
    clk_step;
    tick = 0;
    for (int c = 0; c < 5; c++) clk_step;
    rst = 1; wr_en = 1; wr_addr = 6'd0; wr_data = 16'h0005; tick = 1;
    clk_step;
    rst = 0; wr_en = 0; tick = 0;
    checks += 2;
    if (level_flat !== '0) begin failures++; $display("FAIL rst_mid_levels: got %h want 0", level_flat); end
    if (busy !== 1'b0) begin failures++; $display("FAIL rst_mid_busy: got %b want 0", busy); end
    wr(6'd0, 16'h0003);
    sweep("post_rst");
    exp_flat = '0;
    exp_flat[W*0 +: W] = 16'h0001;
    checks++;
    if (level_flat !== exp_flat) begin failures++; $display("FAIL post_rst_sweep: got %h want %h", level_flat, exp_flat); end
  endtask
  initial begin
    test_reset;
    test_ramp;
    test_saturate;
    test_back_to_back;
    test_snap_abort;
    test_invalid_and_rst;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
